stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, clock cycles per one-second tick (>=2).
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse: start/pause toggle, clear of DONE.
REQ-005 SHALL have port set  input  1  one-cycle pulse: enter/leave SET.
REQ-006 SHALL have port clear  input  1  one-cycle pulse: zero all digits, go IDLE.
REQ-007 SHALL have port mode  input  1  1 = count up, 0 = count down; level input.
REQ-008 SHALL have port digit_sel  input  1  one-cycle pulse: advance selected digit in SET.
REQ-009 SHALL have port inc  input  1  one-cycle pulse: increment selected digit in SET.
REQ-010 SHALL have ports sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD digits of MM:SS.
REQ-011 SHALL have port state  output  3  current FSM state encoding.
REQ-012 SHALL have port set_digit  output  2  selected digit: 0=sec_ones, 1=sec_tens, 2=min_ones, 3=min_tens.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse on up-count rollover 59:59->00:00.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSE, SET, DONE.
REQ-016 SHALL latch mode on each IDLE->RUN transition; mode changes outside IDLE have no effect.
REQ-017 Input priority per cycle SHALL be clear > start > set > digit_sel > inc; lower-priority pulses in the same cycle are ignored.
REQ-018 clear SHALL, from any state, zero all digits, prescaler and set_digit and enter IDLE next cycle.
REQ-019 IDLE: start -> RUN (prescaler zeroed); set -> SET.
REQ-020 RUN: start -> PAUSE; set ignored.
REQ-021 PAUSE: start -> RUN (prescaler retained, not zeroed); set -> SET.
REQ-022 SET: set -> IDLE; digit_sel advances set_digit 0->1->2->3->0; inc increments selected digit modulo its range (ones 0-9, tens 0-5).
REQ-023 DONE: start -> IDLE with digits unchanged (00:00); set ignored.
REQ-024 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, holding in all other states; tick asserts in the cycle prescaler == TICK_DIV-1.
REQ-025 Digits SHALL update on the same rising edge on which tick is asserted (zero added latency).
REQ-026 Up count: sec_ones 0-9 carries to sec_tens 0-5, carries to min_ones 0-9, carries to min_tens 0-5; 59:59 -> 00:00 with wrap pulsed for one cycle, remaining in RUN.
REQ-027 Down count: borrows mirror REQ-026 (sec_ones 0 -> 9 with borrow, tens 0 -> 5 with borrow); on the tick producing 00:00 FSM SHALL enter DONE.
REQ-028 start in IDLE with latched down mode and digits 00:00 SHALL enter DONE (not RUN) next cycle.
REQ-029 Digits SHALL never hold non-BCD or out-of-range values.
REQ-030 done SHALL equal (state == DONE); wrap SHALL be low except per REQ-026.

Reset
REQ-031 reset SHALL asynchronously force state IDLE, all digits 0, prescaler 0, set_digit 0, latched mode 1, done 0, wrap 0.
REQ-032 reset asserted mid-RUN or mid-SET SHALL abandon the operation with no tick, carry or wrap emitted.
REQ-033 After reset deassertion the first active edge SHALL process inputs normally.

Structure
REQ-034 State enum and digit-range constants (ONES_MAX=9, TENS_MAX=5) SHALL live in shared package stopwatch_pkg.
REQ-035 A single sub-module stopwatch_digit (parameter MAX; inputs en, up, load_zero, inc; outputs value, carry) SHALL be instantiated four times.
REQ-036 Carry/borrow chain SHALL be combinational between digit instances; all state SHALL be registered in this module or stopwatch_digit.

Verification (TICK_DIV=4)
REQ-037 mode=1, start -> digits 00:01 after 4 cycles, 00:10 after 40 cycles; start again -> PAUSE, digits frozen 12 cycles.
REQ-038 SET: digit_sel x3, inc x2, digit_sel, inc x3, set -> min_tens=2, sec_ones=3 (20:03), state IDLE.
REQ-039 Preload 00:02, mode=0, start -> 00:01 at cycle 4, 00:00 and done=1 at cycle 8; start -> IDLE.
REQ-040 Preload 59:59, mode=1, start -> at cycle 4 digits 00:00, wrap high exactly one cycle, state RUN.
REQ-041 start, set and clear in same cycle during RUN -> IDLE, 00:00; reset mid-RUN at prescaler 2 -> all outputs at reset values immediately.
REQ-042 inc on sec_tens at 5 -> 0 with no carry into min_ones.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
// Holds the FSM state encoding and the legal digit ranges.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_SET   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned ONES_MAX = 9;
    localparam int unsigned TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit of the stopwatch, range 0..MAX.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   en          - count one step this cycle (direction from up)
//   up          - 1 = increment with rollover, 0 = decrement with borrow
//   load_zero   - force value to 0 (dominates everything else)
//   inc         - manual increment modulo MAX+1, never produces carry
//   value       - current digit value
//   carry       - combinational carry/borrow: en is set and the digit is
//                 at its rollover point for the current direction
module stopwatch_digit #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load_zero,
    input  logic       inc,
    output logic [3:0] value,
    output logic       carry
);

    localparam logic [3:0] MAXV = 4'(MAX);

    logic at_max;
    logic at_zero;

    assign at_max  = (value == MAXV);
    assign at_zero = (value == 4'd0);
    assign carry   = en & (up ? at_max : at_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load_zero) begin
            value <= '0;
        end else if (en) begin
            if (up) begin
                value <= at_max ? 4'd0 : value + 4'd1;
            end else begin
                value <= at_zero ? MAXV : value - 4'd1;
            end
        end else if (inc) begin
            value <= at_max ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch / countdown timer controller.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   start           - pulse: start/pause toggle, leave DONE
//   set             - pulse: enter/leave SET
//   clear           - pulse: zero everything, go IDLE
//   mode            - level: 1 = count up, 0 = count down (latched on start in IDLE)
//   digit_sel, inc  - pulses: choose / increment the digit being edited in SET
//   sec_ones .. min_tens - BCD display digits
//   state           - FSM state encoding (stopwatch_pkg::state_t)
//   set_digit       - digit being edited: 0=sec_ones .. 3=min_tens
//   done            - high while in DONE
//   wrap            - one-cycle pulse after up-count rollover 59:59 -> 00:00
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       set,
    input  logic       clear,
    input  logic       mode,
    input  logic       digit_sel,
    input  logic       inc,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [2:0] state,
    output logic [1:0] set_digit,
    output logic       done,
    output logic       wrap
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          cur_state;
    state_t          next_state;
    logic [PW-1:0]   presc;
    logic            mode_q;
    logic            wrap_q;
    logic            tick;
    logic            to_zero;
    logic            all_zero;
    logic            inc_go;
    logic [3:0]      dig_en;
    logic [3:0]      dig_inc;
    logic [3:0]      dig_carry;

    assign tick     = (cur_state == S_RUN) && (presc == PRESC_LAST);
    assign all_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                      (min_ones == 4'd0) && (min_tens == 4'd0);
    // Down count is about to land on 00:00 on this tick.
    assign to_zero  = tick && !mode_q && (sec_ones == 4'd1) &&
                      (sec_tens == 4'd0) && (min_ones == 4'd0) && (min_tens == 4'd0);

    // Manual increment only when no higher-priority pulse is present.
    assign inc_go = (cur_state == S_SET) && inc && !clear && !start && !set && !digit_sel;

    always_comb begin
        dig_inc = '0;
        dig_inc[set_digit] = inc_go;
    end

    // Ripple enable chain: each digit steps when the one below carries.
    assign dig_en = {dig_carry[2:0], tick};

    stopwatch_digit #(.MAX(ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .en(dig_en[0]), .up(mode_q), .load_zero(clear),
        .inc(dig_inc[0]), .value(sec_ones), .carry(dig_carry[0])
    );
    stopwatch_digit #(.MAX(TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .en(dig_en[1]), .up(mode_q), .load_zero(clear),
        .inc(dig_inc[1]), .value(sec_tens), .carry(dig_carry[1])
    );
    stopwatch_digit #(.MAX(ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .en(dig_en[2]), .up(mode_q), .load_zero(clear),
        .inc(dig_inc[2]), .value(min_ones), .carry(dig_carry[2])
    );
    stopwatch_digit #(.MAX(TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .en(dig_en[3]), .up(mode_q), .load_zero(clear),
        .inc(dig_inc[3]), .value(min_tens), .carry(dig_carry[3])
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = cur_state;
        if (clear) begin
            next_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start) begin
                        next_state = (!mode && all_zero) ? S_DONE : S_RUN;
                    end else if (set) begin
                        next_state = S_SET;
                    end
                end
                S_RUN: begin
                    // Reaching 00:00 wins over a coincident pause so the
                    // timer never sits paused at zero in down mode.
                    if (to_zero) begin
                        next_state = S_DONE;
                    end else if (start) begin
                        next_state = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        next_state = S_RUN;
                    end else if (set) begin
                        next_state = S_SET;
                    end
                end
                S_SET: begin
                    if (!start && set) begin
                        next_state = S_IDLE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        state = cur_state;
        done  = (cur_state == S_DONE);
        wrap  = wrap_q;
    end

    // Prescaler, latched mode, digit selector and wrap pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            mode_q    <= 1'b1;
            set_digit <= '0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= tick && mode_q && dig_carry[3] && !clear;
            if (clear) begin
                presc     <= '0;
                set_digit <= '0;
            end else begin
                if (cur_state == S_IDLE && start) begin
                    presc  <= '0;
                    mode_q <= mode;
                end else if (cur_state == S_RUN) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
                if (cur_state == S_SET && !start && !set && digit_sel) begin
                    set_digit <= set_digit + 2'd1;
                end
            end
        end
    end

endmodule
